// File: rtl/pwm_capture.sv
// pwm_capture -- period / high-time measurement of a PWM waveform.
//
// The asynchronous input is brought into the clk domain through a
// SYNC_STAGES flip-flop chain. The block then counts clk cycles between
// consecutive synchronised rising edges (period) and the synchronised-high
// cycles inside that interval (duty).
//
// Each completed interval is reported on period_out/duty_out with a
// one-cycle meas_valid strobe.
//
// If no rising edge arrives within 2^WIDTH-1 cycles of the previous one:
//   - timeout is set (sticky),
//   - a zero/zero measurement is strobed,
//   - the block waits for a fresh first edge.
//
// Build option:
//   PWM_CAPTURE_FILTER_EN -- when defined, a glitch filter sits after the
//   synchroniser. The filtered level only follows a new value once three
//   consecutive synchronised samples agree. It replaces the raw
//   synchronised level everywhere, including the level output, and adds
//   two cycles of latency.
//
// Parameters:
//   WIDTH        counter / result width
//   SYNC_STAGES  input synchroniser depth (2 or more)
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   ena         capture enable; low forces IDLE and clears the counters
//   pwm_in      asynchronous waveform under measurement
//   period_out  last measured period, clk cycles
//   duty_out    last measured high time, clk cycles
//   meas_valid  one-cycle strobe when period_out/duty_out update
//   timeout     sticky missing-waveform flag
//   level       current synchronised (optionally filtered) input level
module pwm_capture #(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] duty_out,
    output logic             meas_valid,
    output logic             timeout,
    output logic             level
);

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic             prev_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] hcnt_q;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] duty_q;
    logic             valid_q;
    logic             timeout_q;

    logic             sync_s;
    logic             lvl;
    logic             rise;

    assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
    // hist_q holds the two previous synchronised samples. Together with the
    // current sample they form the three-sample agreement window.
    logic [1:0] hist_q;
    logic       filt_q;
    logic       filt_d;

    always_comb begin
        filt_d = filt_q;
        if ((sync_s == hist_q[0]) && (sync_s == hist_q[1])) begin
            filt_d = sync_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], sync_s};
            filt_q <= filt_d;
        end
    end

    // The filtered value is used combinationally so that it switches on the
    // third agreeing sample. This keeps the added latency at two cycles.
    assign lvl = filt_d;
`else
    assign lvl = sync_s;
`endif

    assign rise = lvl & ~prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // Synchroniser and edge history run regardless of ena, so level
            // stays live while capture is disabled.
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            prev_q  <= lvl;
            valid_q <= 1'b0;

            if (!ena) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                hcnt_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // First edge only arms the counters; there is no
                        // complete interval to report yet.
                        if (rise) begin
                            cnt_q   <= ONE;
                            hcnt_q  <= ONE;
                            state_q <= MEAS;
                        end
                    end
                    MEAS: begin
                        // A rise takes priority over the timeout threshold.
                        if (rise) begin
                            period_q <= cnt_q;
                            duty_q   <= hcnt_q;
                            valid_q  <= 1'b1;
                            // cnt_q is at least 1 in MEAS, so this report
                            // always carries a non-zero period.
                            if (cnt_q != '0) begin
                                timeout_q <= 1'b0;
                            end
                            cnt_q  <= ONE;
                            hcnt_q <= ONE;
                        end else if (cnt_q == CNT_MAX) begin
                            // Report before cnt_q would wrap.
                            timeout_q <= 1'b1;
                            valid_q   <= 1'b1;
                            period_q  <= '0;
                            duty_q    <= '0;
                            cnt_q     <= '0;
                            hcnt_q    <= '0;
                            state_q   <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                            if (lvl) begin
                                hcnt_q <= hcnt_q + ONE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign period_out = period_q;
    assign duty_out   = duty_q;
    assign meas_valid = valid_q;
    assign timeout    = timeout_q;
    assign level      = lvl;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture -- directed self-checking bench for pwm_capture.
//
// Inputs are driven on the falling clock edge. A monitor samples the DUT
// 1 time unit after each rising edge and collects every meas_valid report
// into obs_q.
//
// Each scenario pushes its hand-computed {period, duty} pairs into exp_q,
// then compares the two queues.
//
// Define PWM_CAPTURE_FILTER_EN for both the DUT and this bench to exercise
// the filtered build.
module tb_pwm_capture;

    localparam int WIDTH = 12;

`ifdef PWM_CAPTURE_FILTER_EN
    // Edges from the pwm_in rise to the timeout strobe: 4095 + 3 + 2 (filter).
    localparam int TO_EDGES = 4100;
`else
    // Edges from the pwm_in rise to the timeout strobe: 4095 + 3.
    localparam int TO_EDGES = 4098;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             pwm_in;
    logic [WIDTH-1:0] period_out;
    logic [WIDTH-1:0] duty_out;
    logic             meas_valid;
    logic             timeout;
    logic             level;

    pwm_capture #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .pwm_in    (pwm_in),
        .period_out(period_out),
        .duty_out  (duty_out),
        .meas_valid(meas_valid),
        .timeout   (timeout),
        .level     (level)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int vcyc     = 0;
    int wide_cnt = 0;
    int t0       = 0;
    logic valid_prev = 1'b0;
    logic [2*WIDTH-1:0] exp_q[$];
    logic [2*WIDTH-1:0] obs_q[$];

    // Monitor: cyc counts rising edges; outputs are sampled 1 unit later.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (meas_valid) begin
            obs_q.push_back({period_out, duty_out});
            vcyc = cyc;
            if (valid_prev) begin
                wide_cnt++;
            end
        end
        valid_prev = meas_valid;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic exp_meas(input int p, input int d);
        exp_q.push_back({p[WIDTH-1:0], d[WIDTH-1:0]});
    endtask

    task automatic check_meas(input string tag);
        logic [2*WIDTH-1:0] got;
        logic [2*WIDTH-1:0] exp;
        check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            check_eq({tag, "_period"}, {20'd0, got[2*WIDTH-1:WIDTH]},
                     {20'd0, exp[2*WIDTH-1:WIDTH]});
            check_eq({tag, "_duty"}, {20'd0, got[WIDTH-1:0]},
                     {20'd0, exp[WIDTH-1:0]});
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic periods(input int hi, input int lo, input int n);
        repeat (n) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    // Pulse ena low for one cycle with pwm_in low: FSM back to IDLE.
    task automatic restart();
        pwm_in = 1'b0;
        ena    = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        drive(1'b0, 4);
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst    = 1'b1;
        ena    = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check_eq("rst_period",  period_out, 0);
        check_eq("rst_duty",    duty_out, 0);
        check_eq("rst_valid",   meas_valid, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_level",   level, 0);
        rst = 1'b0;
        ena = 1'b1;

        // Clean PWM, high 3 / low 7, 5 periods: 5 rises -> 4 reports.
        restart();
        periods(3, 7, 5);
        repeat (4) exp_meas(10, 3);
        check_meas("clean10");
        check_eq("clean10_width", wide_cnt, 0);

        // Duty sweep at period 16.
        restart();
`ifdef PWM_CAPTURE_FILTER_EN
        // 1-cycle phases would be filtered out, so 3 / 13 is used here.
        periods(3, 13, 1);
        periods(13, 3, 1);
        drive(1'b1, 3);
        drive(1'b0, 8);
        exp_meas(16, 3);
        exp_meas(16, 13);
`else
        periods(1, 15, 1);
        periods(15, 1, 1);
        drive(1'b1, 3);
        drive(1'b0, 8);
        exp_meas(16, 1);
        exp_meas(16, 15);
`endif
        check_meas("sweep16");
        check_eq("sweep16_width", wide_cnt, 0);

        // Stuck-high line: timeout strobe 0/0 after 2^12-1 cycles.
        restart();
        t0 = cyc;
        drive(1'b1, 5000);
        exp_meas(0, 0);
        check_meas("stuck");
        check_eq("stuck_edges",   vcyc - t0, TO_EDGES);
        check_eq("stuck_timeout", timeout, 1);
        check_eq("stuck_level",   level, 1);

        // Timeout stays set through the first edge, then clears with the
        // first non-zero report.
        drive(1'b0, 7);
        drive(1'b1, 3);
        drive(1'b0, 7);
        check_eq("to_sticky", timeout, 1);
        drive(1'b1, 3);
        drive(1'b0, 7);
        check_eq("to_clear", timeout, 0);
        exp_meas(10, 3);
        check_meas("to_recover");

        // Reset in mid-period discards the partial measurement.
        restart();
        periods(3, 7, 2);
        drive(1'b1, 2);
        rst    = 1'b1;
        pwm_in = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_period",  period_out, 0);
        check_eq("midrst_duty",    duty_out, 0);
        check_eq("midrst_valid",   meas_valid, 0);
        check_eq("midrst_timeout", timeout, 0);
        check_eq("midrst_level",   level, 0);
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        drive(1'b0, 6);
        periods(3, 7, 3);
        repeat (2) exp_meas(10, 3);
        check_meas("postrst");

        // ena dropped for 20 cycles during a period-10 waveform.
        restart();
        periods(3, 7, 3);
        repeat (2) exp_meas(10, 3);
        check_meas("ena_pre");
        ena = 1'b0;
        periods(3, 7, 2);
        check_meas("ena_off");
        check_eq("ena_hold_period", period_out, 10);
        check_eq("ena_hold_duty",   duty_out, 3);
        ena = 1'b1;
        periods(3, 7, 3);
        repeat (2) exp_meas(10, 3);
        check_meas("ena_resume");

        // 1-cycle glitch in the low phase.
        restart();
        periods(3, 7, 1);
        drive(1'b1, 3);
        drive(1'b0, 3);
        drive(1'b1, 1);
        drive(1'b0, 3);
        periods(3, 7, 1);
        drive(1'b1, 3);
        drive(1'b0, 8);
`ifdef PWM_CAPTURE_FILTER_EN
        repeat (3) exp_meas(10, 3);
`else
        exp_meas(10, 3);
        exp_meas(6, 3);
        exp_meas(4, 1);
        exp_meas(10, 3);
`endif
        check_meas("glitch");
        check_eq("final_width", wide_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
